// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages around a pipe_skid_reg.
// The stage uses the slave view; the upstream/downstream driver uses master.
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush. Ready is decoded from state only, so no comb path crosses the stage.
module pipe_skid_reg #(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    pipe_skid_reg_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_drain;

    assign w_in_ready  = (r_state != ST_TWO);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;
    assign bus.occupancy = 2'(r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Flush wins over any handshake; a drain during flush is simply absorbed.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
            w_skid_nxt  = BUBBLE_VAL;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt  = bus.in_data;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = BUBBLE_VAL;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg handshake, skid, flush and reset.
module tb_pipe_skid_reg;
    localparam int unsigned W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_skid_reg_if #(.WIDTH(W)) bus ();

    pipe_skid_reg #(.WIDTH(W), .BUBBLE_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0 || bus.out_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_init: valid=%b ready=%b occ=%0d data=%h, required 0 1 0 0000",
                     bus.out_valid, bus.in_ready, bus.occupancy, bus.out_data);
        end
        rst = 1'b0;
        // fill to TWO, then assert reset between edges
        bus.in_valid = 1'b1; bus.in_data = 16'h1111;
        step();
        bus.in_data = 16'h2222;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.occupancy !== 2'd2) begin
            failures++;
            $display("FAIL reset_prefill_occ: got %0d required 2", bus.occupancy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0 || bus.out_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_async: valid=%b ready=%b occ=%0d data=%h, required 0 1 0 0000",
                     bus.out_valid, bus.in_ready, bus.occupancy, bus.out_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        idle_inputs();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.in_data = W'(i);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i) || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b data=%h occ=%0d ready=%b, required 1 %h 1 1",
                         i, bus.out_valid, bus.out_data, bus.occupancy, bus.in_ready, W'(i));
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out_data !== 16'h0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b occ=%0d data=%h, required 0 0 0000",
                     bus.out_valid, bus.occupancy, bus.out_data);
        end
    endtask

    task automatic test_stall_skid();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_data = 16'h00AA;
        step();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.out_data !== 16'h00AA || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_one: occ=%0d data=%h ready=%b, required 1 00aa 1",
                     bus.occupancy, bus.out_data, bus.in_ready);
        end
        bus.in_data = 16'h00BB;
        step();
        checks++;
        if (bus.occupancy !== 2'd2 || bus.out_data !== 16'h00AA || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL skid_two: occ=%0d data=%h ready=%b valid=%b, required 2 00aa 0 1",
                     bus.occupancy, bus.out_data, bus.in_ready, bus.out_valid);
        end
        // upstream keeps offering C while full; it must not be taken in TWO
        bus.in_data = 16'h00CC;
        step();
        checks++;
        if (bus.occupancy !== 2'd2 || bus.out_data !== 16'h00AA) begin
            failures++;
            $display("FAIL skid_hold: occ=%0d data=%h, required 2 00aa", bus.occupancy, bus.out_data);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.occupancy !== 2'd1 || bus.out_data !== 16'h00BB || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_drain_a: occ=%0d data=%h ready=%b, required 1 00bb 1",
                     bus.occupancy, bus.out_data, bus.in_ready);
        end
        step();
        checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            failures++;
            $display("FAIL skid_drain_b: occ=%0d valid=%b data=%h, required 0 0 0000",
                     bus.occupancy, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_data = 16'h0A0A;
        step();
        bus.in_data = 16'h0B0B;
        step();
        bus.flush = 1'b1; bus.in_data = 16'h0C0C;
        bus.in_valid = 1'b1;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_two: occ=%0d valid=%b data=%h ready=%b, required 0 0 0000 1",
                     bus.occupancy, bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data === 16'h0C0C) begin
                failures++;
                $display("FAIL flush_after_%0d: valid=%b data=%h, required 0 0000", i, bus.out_valid, bus.out_data);
            end
        end
        // flush in ONE with simultaneous accept and drain
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0D0D;
        step();
        bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_data = 16'h0E0E;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            failures++;
            $display("FAIL flush_one: occ=%0d valid=%b data=%h, required 0 0 0000",
                     bus.occupancy, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] exp_data;
        logic         acc;
        logic         drn;
        int           rnd_fail;
        logic [W-1:0] next_val;
        idle_inputs();
        rnd_fail = 0;
        next_val = 16'h0100;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = next_val;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_data = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() != 2) ||
                bus.occupancy !== 2'(q.size()) || bus.out_data !== exp_data) begin
                failures++;
                rnd_fail++;
                if (rnd_fail <= 5)
                    $display("FAIL random_c%0d: valid=%b ready=%b occ=%0d data=%h, required %b %b %0d %h",
                             c, bus.out_valid, bus.in_ready, bus.occupancy, bus.out_data,
                             (q.size() != 0), (q.size() != 2), q.size(), exp_data);
            end
            acc = bus.in_valid && (q.size() < 2);
            drn = (q.size() != 0) && bus.out_ready;
            @(posedge clk);
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(next_val);
                next_val = next_val + 16'd1;
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
